// File: rtl/therm_decoder_pipe_if.sv
// Sample/result bus of the thermometer decoder pipeline.
// master = comparator capture side, slave = decoder.
interface therm_decoder_pipe_if #(
    parameter int N_COMP = 14,
    parameter int OUT_W  = 4,
    parameter int N_CH   = 1,
    parameter int CNT_W  = 16
);
    logic                    din_valid;
    logic [N_CH*N_COMP-1:0]  din;
    logic                    err_clr;
    logic                    dout_valid;
    logic [N_CH*OUT_W-1:0]   dout;
    logic [N_CH-1:0]         ovf;
    logic [N_CH-1:0]         bub;
    logic [N_CH-1:0]         err;
    logic [CNT_W-1:0]        err_cnt;

    modport master (
        output din_valid, din, err_clr,
        input  dout_valid, dout, ovf, bub, err, err_cnt
    );

    modport slave (
        input  din_valid, din, err_clr,
        output dout_valid, dout, ovf, bub, err, err_cnt
    );
endinterface

// File: rtl/therm_decoder_pipe.sv
// Pipelined N_CH-channel thermometer-to-binary decoder with bubble
// correction, ovf/bub/err flags and a saturating error counter.
module therm_decoder_pipe #(
    parameter int N_COMP = 14,
    parameter int OUT_W  = 4,
    parameter int N_CH   = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    therm_decoder_pipe_if.slave io_bus
);
    localparam int DW = N_CH * N_COMP;
    localparam int CW = N_CH * OUT_W;

    if (N_COMP < 2 || N_COMP > 63) begin : g_bad_ncomp
        $error("N_COMP must be in 2..63");
    end
    if ((64'd1 << OUT_W) <= 64'(N_COMP)) begin : g_bad_outw
        $error("OUT_W too narrow for N_COMP");
    end

    logic            r_s1_v;
    logic [DW-1:0]   r_s1_d;
    logic [DW-1:0]   w_cor;
    logic [N_CH-1:0] w_ne;
    logic            r_s2_v;
    logic [DW-1:0]   r_s2_t;
    logic [N_CH-1:0] r_s2_ne;
    logic [CW-1:0]   w_code;
    logic [N_CH-1:0] w_ovf;
    logic [N_CH-1:0] w_err;
    logic            r_s3_v;
    logic [CW-1:0]   r_s3_code;
    logic [N_CH-1:0] r_s3_ovf;
    logic [N_CH-1:0] r_s3_err;
    logic [N_CH-1:0] r_s3_bub;
    logic            r_o_v;
    logic [CW-1:0]   r_o_dout;
    logic [N_CH-1:0] r_o_ovf;
    logic [N_CH-1:0] r_o_bub;
    logic [N_CH-1:0] r_o_err;
    logic [CNT_W-1:0] r_err_cnt;

    // Stage 1: capture comparator bank; data holds while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s1_d <= '0;
        end else begin
            r_s1_v <= io_bus.din_valid;
            if (io_bus.din_valid) r_s1_d <= io_bus.din;
        end
    end

    // 3-input majority per bit, padded with 1 below bit 0 and 0 above the top
    always_comb begin
        logic [N_COMP+1:0] v_ext;
        w_cor = '0;
        w_ne  = '0;
        v_ext = '0;
        for (int c = 0; c < N_CH; c++) begin
            v_ext = {1'b0, r_s1_d[c*N_COMP +: N_COMP], 1'b1};
            for (int i = 0; i < N_COMP; i++) begin
                w_cor[c*N_COMP+i] = (v_ext[i]   & v_ext[i+1]) |
                                    (v_ext[i]   & v_ext[i+2]) |
                                    (v_ext[i+1] & v_ext[i+2]);
            end
            w_ne[c] = w_cor[c*N_COMP +: N_COMP] != r_s1_d[c*N_COMP +: N_COMP];
        end
    end

    // Stage 2: register corrected vectors and the changed-bit flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v  <= 1'b0;
            r_s2_t  <= '0;
            r_s2_ne <= '0;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_t  <= w_cor;
                r_s2_ne <= w_ne;
            end
        end
    end

    // Count the run of ones from LSB; any one after the run is an error
    always_comb begin
        logic             v_run;
        logic [OUT_W-1:0] v_cnt;
        w_code = '0;
        w_ovf  = '0;
        w_err  = '0;
        v_run  = 1'b1;
        v_cnt  = '0;
        for (int c = 0; c < N_CH; c++) begin
            v_run = 1'b1;
            v_cnt = '0;
            for (int i = 0; i < N_COMP; i++) begin
                if (r_s2_t[c*N_COMP+i]) begin
                    if (v_run) v_cnt = v_cnt + OUT_W'(1);
                    else       w_err[c] = 1'b1;
                end else begin
                    v_run = 1'b0;
                end
            end
            w_code[c*OUT_W +: OUT_W] = v_cnt;
            w_ovf[c] = v_run;
        end
    end

    // Stage 3: register decoded code and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s3_v    <= 1'b0;
            r_s3_code <= '0;
            r_s3_ovf  <= '0;
            r_s3_err  <= '0;
            r_s3_bub  <= '0;
        end else begin
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                r_s3_code <= w_code;
                r_s3_ovf  <= w_ovf;
                r_s3_err  <= w_err;
                r_s3_bub  <= r_s2_ne;
            end
        end
    end

    // Output registers: load only on a valid stage-3 result, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_v    <= 1'b0;
            r_o_dout <= '0;
            r_o_ovf  <= '0;
            r_o_bub  <= '0;
            r_o_err  <= '0;
        end else begin
            r_o_v <= r_s3_v;
            if (r_s3_v) begin
                r_o_dout <= r_s3_code;
                r_o_ovf  <= r_s3_ovf;
                r_o_bub  <= r_s3_bub;
                r_o_err  <= r_s3_err;
            end
        end
    end

    // Saturating error-sample counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (io_bus.err_clr) begin
            r_err_cnt <= '0;
        end else if (r_s3_v && (|r_s3_err) &&
                     (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign io_bus.dout_valid = r_o_v;
    assign io_bus.dout       = r_o_dout;
    assign io_bus.ovf        = r_o_ovf;
    assign io_bus.bub        = r_o_bub;
    assign io_bus.err        = r_o_err;
    assign io_bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_therm_decoder_pipe.sv
// Scoreboard bench for therm_decoder_pipe: random and directed samples,
// reference decode from the majority/run rules, latency and counter model.
module tb_therm_decoder_pipe;
    localparam int NC  = 14;
    localparam int OW  = 4;
    localparam int NCH = 3;
    localparam int CW  = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [NCH*OW-1:0] dout;
        logic [NCH-1:0]    ovf;
        logic [NCH-1:0]    bub;
        logic [NCH-1:0]    err;
        int                due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    therm_decoder_pipe_if #(.N_COMP(NC), .OUT_W(OW), .N_CH(NCH), .CNT_W(CW)) u_if ();

    therm_decoder_pipe #(.N_COMP(NC), .OUT_W(OW), .N_CH(NCH), .CNT_W(CW)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    exp_t q[$];
    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    int m_cnt  = 0;

    task automatic chk(string nm, longint act, longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    // Reference decode straight from the rules
    function automatic exp_t model(logic [NCH*NC-1:0] d);
        exp_t e;
        logic [NC-1:0] t, tc;
        int s, code, lo, hi;
        e.dout = '0; e.ovf = '0; e.bub = '0; e.err = '0; e.due = 0;
        for (int c = 0; c < NCH; c++) begin
            t = d[c*NC +: NC];
            for (int i = 0; i < NC; i++) begin
                lo = (i == 0) ? 1 : int'(t[(i == 0) ? 0 : i-1]);
                hi = (i == NC-1) ? 0 : int'(t[(i == NC-1) ? i : i+1]);
                s = lo + int'(t[i]) + hi;
                tc[i] = (s >= 2);
            end
            code = 0;
            while (code < NC && tc[code]) code++;
            e.dout[c*OW +: OW] = OW'(code);
            e.ovf[c] = (code == NC);
            e.err[c] = (int'(tc) != ((1 << code) - 1));
            e.bub[c] = (tc != t);
        end
        return e;
    endfunction

    function automatic logic [NC-1:0] therm(int k);
        logic [NC:0] v;
        v = (NC+1)'((1 << k) - 1);
        return v[NC-1:0];
    endfunction

    function automatic logic [NC-1:0] rnd_ch();
        logic [NC-1:0] t;
        t = therm($urandom_range(0, NC));
        if ($urandom_range(0, 2) == 0) t[$urandom_range(0, NC-1)] ^= 1'b1;
        if ($urandom_range(0, 5) == 0) t[$urandom_range(0, NC-1)] ^= 1'b1;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [NCH*NC-1:0] d);
        exp_t e;
        u_if.din_valid = 1'b1;
        u_if.din = d;
        e = model(d);
        e.due = cyc + 4;
        q.push_back(e);
        step();
    endtask

    task automatic idle(int n);
        u_if.din_valid = 1'b0;
        u_if.din = {rnd_ch(), rnd_ch(), rnd_ch()};
        repeat (n) step();
    endtask

    task automatic drain(string nm);
        u_if.din_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk(nm, q.size(), 0);
        step();
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        u_if.din_valid = 1'b0;
        u_if.err_clr = 1'b0;
        q.delete();
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Monitor: pops expected results and tracks the error counter
    initial begin
        exp_t e;
        logic clr_q, rst_q;
        forever begin
            @(posedge clk);
            cyc++;
            clr_q = u_if.err_clr;
            rst_q = rst;
            @(negedge clk);
            if (rst_q) begin
                m_cnt = 0;
                chk("reset_state", {u_if.dout_valid, u_if.dout, u_if.ovf,
                                    u_if.bub, u_if.err, u_if.err_cnt}, 0);
            end else begin
                if (u_if.dout_valid) begin
                    n_out++;
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc, e.due);
                        chk("dout", u_if.dout, e.dout);
                        chk("ovf", u_if.ovf, e.ovf);
                        chk("bub", u_if.bub, e.bub);
                        chk("err", u_if.err, e.err);
                        if (e.err != 0 && m_cnt < CMAX) m_cnt++;
                    end
                end
                if (clr_q) m_cnt = 0;
                chk("err_cnt", u_if.err_cnt, m_cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        u_if.din_valid = 1'b0;
        u_if.din = '0;
        u_if.err_clr = 1'b0;
        do_reset(3);
        step();
        chk("idle_valid", u_if.dout_valid, 0);

        // Legal code sweep on ch0, back-to-back
        for (int k = 0; k <= NC; k++) send({rnd_ch(), rnd_ch(), therm(k)});
        drain("sweep_drain");
        chk("sweep_ovf_last", u_if.ovf[0], 1);
        chk("sweep_code_last", u_if.dout[OW-1:0], NC);

        // Bubbles and gross error
        send({therm(0), therm(0), 14'h00F7});
        drain("bub_drain");
        chk("bub_f7_code", u_if.dout[OW-1:0], 8);
        chk("bub_f7_flag", u_if.bub[0], 1);
        send({therm(0), therm(0), 14'h0002});
        send({therm(0), therm(0), 14'h0F0F});
        drain("err_drain");
        chk("gross_code", u_if.dout[OW-1:0], 4);
        chk("gross_err", u_if.err, 3'b001);

        // Throughput: 6 back-to-back, gap, 2 more
        base = n_out;
        for (int i = 0; i < 6; i++) send({rnd_ch(), rnd_ch(), rnd_ch()});
        idle(3);
        for (int i = 0; i < 2; i++) send({rnd_ch(), rnd_ch(), rnd_ch()});
        drain("tput_drain");
        chk("tput_strobes", n_out - base, 8);

        // Counter saturation and clear
        u_if.err_clr = 1'b1;
        step();
        u_if.err_clr = 1'b0;
        for (int i = 0; i < 5; i++) send({therm(0), therm(0), 14'h0F0F});
        drain("sat_drain");
        chk("cnt_sat", u_if.err_cnt, CMAX);
        send({therm(0), therm(0), 14'h0F0F});
        idle(2);
        u_if.err_clr = 1'b1;
        idle(1);
        u_if.err_clr = 1'b0;
        idle(1);
        chk("cnt_clr_coincide", u_if.err_cnt, 0);
        send({therm(0), therm(0), 14'h0F0F});
        drain("clr_drain");
        chk("cnt_after_clr", u_if.err_cnt, 1);

        // Multi-channel directed
        send({14'h0FF7, 14'h0000, 14'h001F});
        drain("mc_drain");
        chk("mc_dout", u_if.dout, {4'd12, 4'd0, 4'd5});
        chk("mc_bub", u_if.bub, 3'b100);

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            u_if.err_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) send({rnd_ch(), rnd_ch(), rnd_ch()});
            else idle(1);
        end
        u_if.err_clr = 1'b0;
        drain("rand_drain");

        // Reset two cycles after a valid sample discards it
        base = n_out;
        send({therm(3), therm(7), therm(9)});
        idle(1);
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_valid_after_rst", u_if.dout_valid, 0);
        end
        chk("rst_strobes", n_out - base, 0);
        chk("rst_outputs", {u_if.dout, u_if.ovf, u_if.bub, u_if.err, u_if.err_cnt}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
